// File: rtl/output_port_pkg.sv
// Shared types and default sizing for the output port.
`include "constants.sv"

package output_port_pkg;

    localparam int DEF_DEPTH = `OUT_DEPTH;
    localparam int DEF_WIDTH = `WORD_WIDTH;

    // Per-cycle queue operation decided by the handshake logic.
    typedef struct packed {
        logic push;
        logic pop;
    } fifo_op_t;

endpackage

// File: rtl/constants.sv
// Word width and output-queue depth shared by the control unit, datapath and output port.
`ifndef CONSTANTS_SV
`define CONSTANTS_SV
`define WORD_WIDTH 16
`define OUT_DEPTH 4
`endif

// File: rtl/output_port_fifo.sv
// Storage and wrap-around pointers for the output queue; the read is
// combinational so the head word falls through to the consumer.
module out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;

    // DEPTH is a power of two, so natural overflow of the pointers gives the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];

endmodule

// File: rtl/output_port.sv
// First-word-fall-through output queue between the OUT instruction and an
// external consumer. Define OUTPUT_OVERFLOW_EN to add the sticky overflow flag.
module output_port
    import output_port_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         output_valid,
    input  logic [WIDTH-1:0]             out_data,
    output logic [WIDTH-1:0]             port_data,
    output logic                         port_valid,
    input  logic                         port_ready,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef OUTPUT_OVERFLOW_EN
    ,
    output logic                         overflow
`endif
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0] r_count;
    logic             w_valid;
    logic             w_full;
    logic [WIDTH-1:0] w_rdata;
    fifo_op_t         w_op;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == FULL_CNT);

    // A full queue still accepts a word when the head leaves in the same cycle.
    always_comb begin
        w_op.pop  = w_valid && port_ready;
        w_op.push = output_valid && (!w_full || w_op.pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_op.push, w_op.pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_op.push),
        .i_pop   (w_op.pop),
        .i_wdata (out_data),
        .o_rdata (w_rdata)
    );

    assign port_valid = w_valid;
    assign port_data  = w_valid ? w_rdata : '0;
    assign full       = w_full;
    assign count      = r_count;

`ifdef OUTPUT_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (output_valid && !w_op.push) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_output_port.sv
// Self-checking bench for output_port: directed vector table, hand-written
// reset/wrap sequences and a randomized run against a queue reference model.
module tb_output_port;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             clk;
    logic             rst;
    logic             output_valid;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] port_data;
    logic             port_valid;
    logic             port_ready;
    logic             full;
    logic [CNT_W-1:0] count;
`ifdef OUTPUT_OVERFLOW_EN
    logic             overflow;
`endif

    output_port #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .output_valid (output_valid),
        .out_data     (out_data),
        .port_data    (port_data),
        .port_valid   (port_valid),
        .port_ready   (port_ready),
        .full         (full),
        .count        (count)
`ifdef OUTPUT_OVERFLOW_EN
        ,
        .overflow     (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: an unbounded queue limited to DEPTH by the acceptance rule.
    logic [WIDTH-1:0] mq[$];
    bit               m_ovf;

    typedef struct {
        bit               ov;
        logic [WIDTH-1:0] d;
        bit               rdy;
        bit               e_valid;
        logic [WIDTH-1:0] e_data;
        int               e_count;
        bit               e_full;
    } vec_t;

    vec_t tv[15];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(bit ov, logic [WIDTH-1:0] d, bit rdy);
        bit pop;
        bit push;
        pop  = (mq.size() != 0) && rdy;
        push = ov && ((mq.size() < DEPTH) || pop);
        if (ov && !push) m_ovf = 1'b1;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(d);
    endtask

    task automatic apply(bit ov, logic [WIDTH-1:0] d, bit rdy);
        output_valid = ov;
        out_data     = d;
        port_ready   = rdy;
        @(posedge clk);
        model_step(ov, d, rdy);
        #1;
    endtask

    task automatic check_model(string tag);
        logic [WIDTH-1:0] head;
        head = (mq.size() != 0) ? mq[0] : '0;
        chk({tag, ".valid"}, 32'(port_valid), 32'(mq.size() != 0));
        chk({tag, ".data"},  32'(port_data),  32'(head));
        chk({tag, ".count"}, 32'(count),      32'(mq.size()));
        chk({tag, ".full"},  32'(full),       32'(mq.size() == DEPTH));
`ifdef OUTPUT_OVERFLOW_EN
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
`endif
    endtask

    initial begin
        // ov, data, rdy -> expected valid, data, count, full after the edge
        tv[0]  = '{1'b1, 16'hA5A5, 1'b0, 1'b1, 16'hA5A5, 1, 1'b0};
        tv[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b0};
        tv[2]  = '{1'b1, 16'h0001, 1'b0, 1'b1, 16'h0001, 1, 1'b0};
        tv[3]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 16'h0001, 2, 1'b0};
        tv[4]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 16'h0001, 3, 1'b0};
        tv[5]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 16'h0001, 4, 1'b1};
        tv[6]  = '{1'b1, 16'h0005, 1'b0, 1'b1, 16'h0001, 4, 1'b1};
        tv[7]  = '{1'b1, 16'h0009, 1'b1, 1'b1, 16'h0002, 4, 1'b1};
        tv[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 3, 1'b0};
        tv[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 2, 1'b0};
        tv[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0009, 1, 1'b0};
        tv[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b0};
        tv[12] = '{1'b1, 16'h0007, 1'b1, 1'b1, 16'h0007, 1, 1'b0};
        tv[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0007, 1, 1'b0};
        tv[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b0};

        rst          = 1'b1;
        output_valid = 1'b0;
        out_data     = '0;
        port_ready   = 1'b0;
        m_ovf        = 1'b0;
        #2;
        chk("reset.valid", 32'(port_valid), 32'd0);
        chk("reset.count", 32'(count),      32'd0);
        chk("reset.full",  32'(full),       32'd0);
        chk("reset.data",  32'(port_data),  32'd0);
`ifdef OUTPUT_OVERFLOW_EN
        chk("reset.overflow", 32'(overflow), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed table: first push lands on the first edge after reset release.
        for (int i = 0; i < 15; i++) begin
            apply(tv[i].ov, tv[i].d, tv[i].rdy);
            $display("vec %0d: ov=%0b d=%h rdy=%0b -> valid=%0b data=%h count=%0d full=%0b",
                     i, tv[i].ov, tv[i].d, tv[i].rdy, port_valid, port_data, count, full);
            chk($sformatf("vec%0d.valid", i), 32'(port_valid), 32'(tv[i].e_valid));
            chk($sformatf("vec%0d.data", i),  32'(port_data),  32'(tv[i].e_data));
            chk($sformatf("vec%0d.count", i), 32'(count),      32'(tv[i].e_count));
            chk($sformatf("vec%0d.full", i),  32'(full),       32'(tv[i].e_full));
        end
`ifdef OUTPUT_OVERFLOW_EN
        chk("table.overflow", 32'(overflow), 32'd1);
`endif

        // Asynchronous reset mid-cycle with three words queued.
        for (int i = 0; i < 3; i++) apply(1'b1, 16'h0030 + 16'(i), 1'b0);
        chk("pre_rst.count", 32'(count), 32'd3);
        output_valid = 1'b0;
        port_ready   = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        $display("async rst: valid=%0b count=%0d data=%h", port_valid, count, port_data);
        chk("arst.valid", 32'(port_valid), 32'd0);
        chk("arst.count", 32'(count),      32'd0);
        chk("arst.full",  32'(full),       32'd0);
        chk("arst.data",  32'(port_data),  32'd0);
`ifdef OUTPUT_OVERFLOW_EN
        chk("arst.overflow", 32'(overflow), 32'd0);
`endif
        #1;
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        apply(1'b1, 16'h00FF, 1'b0);
        $display("post rst strobe: valid=%0b data=%h count=%0d", port_valid, port_data, count);
        chk("post_rst.valid", 32'(port_valid), 32'd1);
        chk("post_rst.data",  32'(port_data),  32'h00FF);
        chk("post_rst.count", 32'(count),      32'd1);
        apply(1'b0, 16'h0000, 1'b1);
        chk("post_rst.drain", 32'(count), 32'd0);

        // Ten push/pop pairs: each cycle the previous word leaves and a new one arrives.
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 16'h0100 + 16'(i), 1'b1);
            $display("pair %0d: data=%h count=%0d", i, port_data, count);
            chk($sformatf("pair%0d.data", i),  32'(port_data), 32'h0100 + 32'(i));
            chk($sformatf("pair%0d.count", i), 32'(count),     32'd1);
        end
        apply(1'b0, 16'h0000, 1'b1);
        chk("pairs.drain", 32'(count), 32'd0);

        // Randomized traffic against the reference queue.
        for (int i = 0; i < 400; i++) begin
            bit               ov;
            bit               rdy;
            logic [WIDTH-1:0] d;
            ov  = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
            d   = 16'($urandom);
            apply(ov, d, rdy);
            $display("rand %0d: ov=%0b d=%h rdy=%0b -> valid=%0b data=%h count=%0d",
                     i, ov, d, rdy, port_valid, port_data, count);
            check_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
